// File: rtl/scan_sequencer_if.sv
// Error-record channel of the pair scan sequencer (valid/ready handshake).
interface scan_sequencer_if #(
  parameter int N_PAIR = 86,
  parameter int IDX_W  = 7
);
  logic              err_valid;
  logic              err_ready;
  logic [IDX_W-1:0]  err_index;
  logic [N_PAIR-1:0] err_diff;

  modport master (output err_valid, output err_index, output err_diff, input err_ready);
  modport slave  (input err_valid, input err_index, input err_diff, output err_ready);
endinterface

// File: rtl/scan_sequencer.sv
// Start/done sequenced walking-zero scan of open-drain pad pairs with error reporting.
// Optional OPEN phase (all pads released, expect all ones) enabled by `define SCAN_OPEN_CHECK_EN.
module scan_sequencer #(
  parameter int N_PAIR     = 86,
  parameter int IDX_W      = 7,
  parameter int SETTLE_CYC = 31
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [N_PAIR-1:0]  pair_mask,
  input  logic [N_PAIR-1:0]  scan_input,
  output logic [N_PAIR-1:0]  scan_output,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [7:0]         fail_count,
  scan_sequencer_if.master   err
);

  typedef enum logic [2:0] {
    IDLE, DRIVE, SETTLE, SAMPLE, COMPARE, REPORT, NEXT, FINISH
  } state_t;

  localparam logic [N_PAIR-1:0] ONE = N_PAIR'(1);

  state_t            state, state_nxt;
  logic [N_PAIR-1:0] mask_q;
  logic [N_PAIR-1:0] obs;
  logic [N_PAIR-1:0] diff;
  logic [IDX_W-1:0]  step;
  logic [7:0]        settle_cnt;
  logic              open_ph;
  logic              last_step;
  logic              step_masked;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // During the OPEN phase scan_output is all ones, so the same diff gives the open check.
  assign diff        = (obs ^ scan_output) & ~mask_q;
  assign last_step   = (step == IDX_W'(N_PAIR - 1));
  assign step_masked = (|(mask_q & (ONE << step))) && !open_ph;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = DRIVE;
      DRIVE:   state_nxt = step_masked ? NEXT : SETTLE;
      // Counter is loaded with SETTLE_CYC; leaving at 1 gives exactly SETTLE_CYC cycles here.
      SETTLE:  if (settle_cnt <= 8'd1) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = COMPARE;
      COMPARE: state_nxt = (diff != '0) ? REPORT : NEXT;
      REPORT:  if (err.err_ready) state_nxt = NEXT;
      NEXT:    state_nxt = (last_step && !open_ph) ? FINISH : DRIVE;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scan_output   <= '1;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      fail_count    <= 8'd0;
      err.err_valid <= 1'b0;
      err.err_index <= '0;
      err.err_diff  <= '0;
      mask_q        <= '0;
      step          <= '0;
      settle_cnt    <= 8'd0;
      open_ph       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mask_q     <= pair_mask;
            fail_count <= 8'd0;
            pass       <= 1'b0;
            step       <= '0;
            busy       <= 1'b1;
`ifdef SCAN_OPEN_CHECK_EN
            open_ph    <= 1'b1;
`else
            open_ph    <= 1'b0;
`endif
          end
        end
        DRIVE: begin
          if (!step_masked) begin
            scan_output <= open_ph ? '1 : ~(ONE << step);
            settle_cnt  <= 8'(SETTLE_CYC);
          end
        end
        SETTLE: settle_cnt <= settle_cnt - 8'd1;
        COMPARE: begin
          if (diff != '0) begin
            fail_count    <= sat_inc(fail_count);
            err.err_valid <= 1'b1;
            err.err_index <= open_ph ? '1 : step;
            err.err_diff  <= diff;
          end
        end
        REPORT: if (err.err_ready) err.err_valid <= 1'b0;
        NEXT: begin
          scan_output <= '1;
          if (open_ph)         open_ph <= 1'b0;
          else if (!last_step) step    <= step + 1'b1;
        end
        FINISH: begin
          done <= 1'b1;
          busy <= 1'b0;
          pass <= (fail_count == 8'd0);
        end
        default: ;
      endcase
    end
  end

  // Observation register is pure data: only meaningful after SAMPLE.
  always_ff @(posedge clk) begin
    if (state == SAMPLE) obs <= scan_input;
  end

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer: N_PAIR=8, SETTLE_CYC=3, behavioural loop-back fault models.
module tb_scan_sequencer;

`ifdef SCAN_OPEN_CHECK_EN
  localparam int OPEN_CYC = 7;
  localparam logic [7:0] FIRST_PAT = 8'hFF;
`else
  localparam int OPEN_CYC = 0;
  localparam logic [7:0] FIRST_PAT = 8'hFE;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [7:0] pair_mask;
  logic [7:0] scan_input;
  logic [7:0] scan_output;
  logic       busy, done, pass;
  logic [7:0] fail_count;
  logic       rdy;
  int         mode;

  int errors = 0;
  int checks = 0;

  logic [6:0] rec_idx[$];
  logic [7:0] rec_diff[$];
  int         done_cnt = 0;
  int         masked_low_cnt = 0;

  scan_sequencer_if #(.N_PAIR(8), .IDX_W(7)) eif ();

  scan_sequencer #(.N_PAIR(8), .IDX_W(7), .SETTLE_CYC(3)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .pair_mask   (pair_mask),
    .scan_input  (scan_input),
    .scan_output (scan_output),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .fail_count  (fail_count),
    .err         (eif.master)
  );

  assign eif.err_ready = rdy;

  always #5 clk = ~clk;

  // Loop-back fault models: 0 ideal, 1 pair3 stuck high, 2 pairs 2/5 shorted (wired AND),
  // 3 pair0 stuck low, 4 pair6 stuck low.
  always_comb begin
    scan_input = scan_output;
    case (mode)
      1: scan_input = scan_output | 8'h08;
      2: begin
        scan_input[2] = scan_output[2] & scan_output[5];
        scan_input[5] = scan_output[2] & scan_output[5];
      end
      3: scan_input = scan_output & 8'hFE;
      4: scan_input = scan_output & 8'hBF;
      default: ;
    endcase
  end

  always @(negedge clk) begin
    if (eif.err_valid && eif.err_ready) begin
      rec_idx.push_back(eif.err_index);
      rec_diff.push_back(eif.err_diff);
    end
    if (done) done_cnt++;
    if (busy && ((~scan_output & 8'h81) != 8'h00)) masked_low_cnt++;
  end

  // Starts a scan; cyc is the cycle offset from the start cycle t at which done is seen (-1 on timeout).
  task automatic start_and_wait(input logic [7:0] mask, output int cyc);
    pair_mask = mask;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (done !== 1'b1) cyc = -1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (scan_output !== 8'hFF) begin errors++; $display("FAIL reset_scan_output got=%h exp=ff", scan_output); end
    checks++; if ({busy, done, pass, eif.err_valid} !== 4'b0000) begin errors++; $display("FAIL reset_flags got=%b exp=0000", {busy, done, pass, eif.err_valid}); end
    checks++; if (fail_count !== 8'd0) begin errors++; $display("FAIL reset_fail_count got=%0d exp=0", fail_count); end
    checks++; if ({eif.err_index, eif.err_diff} !== 15'd0) begin errors++; $display("FAIL reset_err_record got=%h/%h exp=0/0", eif.err_index, eif.err_diff); end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_ideal();
    int cyc;
    int base;
    mode = 0;
    base = rec_idx.size();
    pair_mask = 8'h00;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ideal_busy_t1 got=%b exp=1", busy); end
    checks++; if (scan_output !== 8'hFF) begin errors++; $display("FAIL ideal_out_t1 got=%h exp=ff", scan_output); end
    @(posedge clk); #1;
    checks++; if (scan_output !== FIRST_PAT) begin errors++; $display("FAIL ideal_out_t2 got=%h exp=%h", scan_output, FIRST_PAT); end
    cyc = 2;
    while (done !== 1'b1 && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (done !== 1'b1) cyc = -1;
    checks++; if (cyc != 58 + OPEN_CYC) begin errors++; $display("FAIL ideal_done_latency got=%0d exp=%0d", cyc, 58 + OPEN_CYC); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ideal_busy_at_done got=%b exp=0", busy); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL ideal_pass got=%b exp=1", pass); end
    checks++; if (fail_count !== 8'd0) begin errors++; $display("FAIL ideal_fail_count got=%0d exp=0", fail_count); end
    checks++; if (rec_idx.size() != base) begin errors++; $display("FAIL ideal_records got=%0d exp=0", rec_idx.size() - base); end
    @(posedge clk); #1;
    checks++; if ({done, pass} !== 2'b01) begin errors++; $display("FAIL ideal_after_done got=%b exp=01", {done, pass}); end
  endtask

  task automatic test_stuck_high();
    int cyc;
    int base;
    mode = 1;
    base = rec_idx.size();
    start_and_wait(8'h00, cyc);
    checks++; if (cyc != 59 + OPEN_CYC) begin errors++; $display("FAIL stuck_done_latency got=%0d exp=%0d", cyc, 59 + OPEN_CYC); end
    checks++; if (rec_idx.size() - base != 1) begin errors++; $display("FAIL stuck_records got=%0d exp=1", rec_idx.size() - base); end
    checks++; if (rec_idx[base] !== 7'd3) begin errors++; $display("FAIL stuck_index got=%h exp=03", rec_idx[base]); end
    checks++; if (rec_diff[base] !== 8'h08) begin errors++; $display("FAIL stuck_diff got=%h exp=08", rec_diff[base]); end
    checks++; if ({pass, fail_count} !== {1'b0, 8'd1}) begin errors++; $display("FAIL stuck_result got=%b/%0d exp=0/1", pass, fail_count); end
  endtask

  task automatic test_short();
    int cyc;
    int base;
    mode = 2;
    base = rec_idx.size();
    start_and_wait(8'h00, cyc);
    checks++; if (rec_idx.size() - base != 2) begin errors++; $display("FAIL short_records got=%0d exp=2", rec_idx.size() - base); end
    checks++; if ({rec_idx[base], rec_diff[base]} !== {7'd2, 8'h20}) begin errors++; $display("FAIL short_rec0 got=%h/%h exp=02/20", rec_idx[base], rec_diff[base]); end
    checks++; if ({rec_idx[base+1], rec_diff[base+1]} !== {7'd5, 8'h04}) begin errors++; $display("FAIL short_rec1 got=%h/%h exp=05/04", rec_idx[base+1], rec_diff[base+1]); end
    checks++; if ({pass, fail_count} !== {1'b0, 8'd2}) begin errors++; $display("FAIL short_result got=%b/%0d exp=0/2", pass, fail_count); end
  endtask

  task automatic test_mask();
    int cyc;
    int base;
    int low0;
    mode = 3;
    base = rec_idx.size();
    low0 = masked_low_cnt;
    start_and_wait(8'h81, cyc);
    checks++; if (cyc != 48 + OPEN_CYC) begin errors++; $display("FAIL mask_done_latency got=%0d exp=%0d", cyc, 48 + OPEN_CYC); end
    checks++; if (masked_low_cnt != low0) begin errors++; $display("FAIL mask_driven_cycles got=%0d exp=0", masked_low_cnt - low0); end
    checks++; if ({pass, fail_count} !== {1'b1, 8'd0}) begin errors++; $display("FAIL mask_result got=%b/%0d exp=1/0", pass, fail_count); end
    checks++; if (rec_idx.size() != base) begin errors++; $display("FAIL mask_records got=%0d exp=0", rec_idx.size() - base); end
  endtask

  task automatic test_stall_reset();
    int n;
    int dc0;
    mode = 1;
    rdy = 1'b0;
    pair_mask = 8'h00;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (eif.err_valid !== 1'b1 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    checks++; if (eif.err_valid !== 1'b1) begin errors++; $display("FAIL stall_valid_seen got=%b exp=1", eif.err_valid); end
    for (int i = 0; i < 20; i++) begin
      start = (i == 5);
      @(posedge clk); #1;
      checks++;
      if ({eif.err_valid, scan_output, eif.err_index, eif.err_diff} !== {1'b1, 8'hF7, 7'd3, 8'h08}) begin
        errors++;
        $display("FAIL stall_hold cyc=%0d got=%b/%h/%h/%h exp=1/f7/03/08", i, eif.err_valid, scan_output, eif.err_index, eif.err_diff);
      end
    end
    start = 1'b0;
    checks++; if ({busy, fail_count} !== {1'b1, 8'd1}) begin errors++; $display("FAIL stall_start_ignored got=%b/%0d exp=1/1", busy, fail_count); end
    dc0 = done_cnt;
    #3;
    reset_n = 1'b0;
    #1;
    checks++; if (scan_output !== 8'hFF) begin errors++; $display("FAIL async_reset_out got=%h exp=ff", scan_output); end
    checks++; if ({busy, eif.err_valid} !== 2'b00) begin errors++; $display("FAIL async_reset_flags got=%b exp=00", {busy, eif.err_valid}); end
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (done_cnt != dc0) begin errors++; $display("FAIL reset_no_done got=%0d exp=0", done_cnt - dc0); end
    checks++; if ({busy, scan_output} !== {1'b0, 8'hFF}) begin errors++; $display("FAIL reset_idle got=%b/%h exp=0/ff", busy, scan_output); end
  endtask

`ifdef SCAN_OPEN_CHECK_EN
  task automatic test_open_check();
    int cyc;
    int base;
    mode = 4;
    base = rec_idx.size();
    start_and_wait(8'hBF, cyc);
    checks++; if (cyc != 31) begin errors++; $display("FAIL open_done_latency got=%0d exp=31", cyc); end
    checks++; if (rec_idx.size() - base != 1) begin errors++; $display("FAIL open_records got=%0d exp=1", rec_idx.size() - base); end
    checks++; if ({rec_idx[base], rec_diff[base]} !== {7'h7F, 8'h40}) begin errors++; $display("FAIL open_record got=%h/%h exp=7f/40", rec_idx[base], rec_diff[base]); end
    checks++; if ({pass, fail_count} !== {1'b0, 8'd1}) begin errors++; $display("FAIL open_result got=%b/%0d exp=0/1", pass, fail_count); end
  endtask
`endif

  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    pair_mask = 8'h00;
    rdy = 1'b1;
    mode = 0;
    test_reset();
    test_ideal();
    test_stuck_high();
    test_short();
    test_mask();
    test_stall_reset();
    test_ideal();
`ifdef SCAN_OPEN_CHECK_EN
    test_open_check();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
